// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: oversampling serial frame decoder with start-glitch rejection and majority-voted bits
// Ports: clk, rst_n (async, active-low), sample_en (sample strobe), rx_in (raw line, idle low,
//   start high, stop low) -> code (last good frame), code_valid / frame_err (one-clk pulses), busy.
// Optional: define RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rx_frame_decoder #(
  parameter int SPB       = 10,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       rx_in,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [4:0] LAST_S = 5'(SPB - 1);
  localparam logic [4:0] HALF   = 5'((SPB + 1) / 2);
  localparam logic [6:0] SPB7   = 7'(SPB);
  localparam logic [2:0] LAST_B = 3'(DATA_BITS - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t                 state_q;
  logic                   rx_meta_q, rx_s_q;
  logic [4:0]             scnt_q, ones_q;
  logic [2:0]             bidx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [7:0]             code_q;
  logic                   code_valid_q, frame_err_q;
  logic [4:0]             ones_d;
  logic [6:0]             dbl;
  logic                   last_s, maj, stop_ok;
  logic [DATA_BITS:0]     shift_w;
`ifdef RX_PARITY_EN
  logic                   par_err_q;
`endif
  assign ones_d  = ones_q + 5'(rx_s_q);
  assign dbl     = {1'b0, ones_d, 1'b0};
  assign last_s  = scnt_q == LAST_S;
  assign maj     = dbl > SPB7;
  assign shift_w = {maj, shreg_q};
`ifdef RX_PARITY_EN
  assign stop_ok = (dbl < SPB7) && !par_err_q;
`else
  assign stop_ok = dbl < SPB7;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b0;
      rx_s_q       <= 1'b0;
      state_q      <= IDLE;
      scnt_q       <= '0;
      ones_q       <= '0;
      bidx_q       <= '0;
      shreg_q      <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_in;
      rx_s_q       <= rx_meta_q;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (sample_en) begin
        // counters wrap at the last sample of each bit; states override as needed
        scnt_q <= last_s ? 5'd0 : scnt_q + 5'd1;
        ones_q <= last_s ? 5'd0 : ones_d;
        case (state_q)
          IDLE: begin
            scnt_q  <= 5'(rx_s_q);
            ones_q  <= '0;
            state_q <= rx_s_q ? START : IDLE;
          end
          START: begin
            if (!rx_s_q && scnt_q < HALF) begin
              state_q <= IDLE;
              scnt_q  <= '0;
            end else if (last_s) begin
              state_q <= DATA;
              bidx_q  <= '0;
            end
          end
          DATA: begin
            if (last_s) begin
              shreg_q <= shift_w[DATA_BITS:1];
              bidx_q  <= bidx_q + 3'd1;
`ifdef RX_PARITY_EN
              if (bidx_q == LAST_B) state_q <= PARITY;
`else
              if (bidx_q == LAST_B) state_q <= STOP;
`endif
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (last_s) begin
              par_err_q <= (^shreg_q) ^ maj;
              state_q   <= STOP;
            end
          end
`endif
          STOP: begin
            if (last_s) begin
              state_q      <= IDLE;
              bidx_q       <= '0;
              code_q       <= stop_ok ? 8'(shreg_q) : code_q;
              code_valid_q <= stop_ok;
              frame_err_q  <= !stop_ok;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = state_q != IDLE;
endmodule
